char_buf_ctrl_16x16: RTL

//  Owns the 16x16 on-screen text buffer (256 x 7-bit char codes) feeding draw_char.

---
 rtl/char_buf_ctrl_16x16.sv | 108 ++++++++++
 1 files changed

// File: rtl/char_buf_ctrl_16x16.sv
// 16x16 on-screen text buffer: registered read port for draw_char, one shared write port
// arbitrated round-robin between two writers, and a full-buffer clear after reset or on request.
module char_buf_ctrl_16x16 #(
  parameter logic [6:0] CLR_CODE = 7'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       clear,
  output logic       busy,
  input  logic [1:0] wr_req,
  input  logic [7:0] wr_addr0,
  input  logic [6:0] wr_data0,
  input  logic [7:0] wr_addr1,
  input  logic [6:0] wr_data1,
  output logic [1:0] wr_gnt
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e     state_q;
  logic [7:0] clr_cnt_q;
  logic       rr_q;
  logic [6:0] char_code_q;
  logic       busy_q;

  logic [6:0] mem_q [256];

  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;

  // Grant is combinational so the write commits on the same edge the writer sees it.
  always_comb begin
    wr_gnt = 2'b00;
    if (state_q == StIdle && !clear) begin
      unique case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = rr_q ? 2'b01 : 2'b10;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = CLR_CODE;
    if (state_q == StClear) begin
      mem_we = 1'b1;
    end else if (wr_gnt[0]) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr0;
      mem_wdata = wr_data0;
    end else if (wr_gnt[1]) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr1;
      mem_wdata = wr_data1;
    end
  end

  // Contents are not reset; the clear sweep initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_cnt_q   <= 8'd0;
      rr_q        <= 1'b0;
      char_code_q <= CLR_CODE;
      busy_q      <= 1'b1;
    end else begin
      // Read-first; stale contents are masked while the sweep runs.
      char_code_q <= (state_q == StClear) ? CLR_CODE : mem_q[char_xy];
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 8'd1;
          if (clear) begin
            clr_cnt_q <= 8'd0;
          end else if (clr_cnt_q == 8'hff) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (clear) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_cnt_q <= 8'd0;
          end else if (wr_gnt != 2'b00) begin
            rr_q <= wr_gnt[1];
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign char_code = char_code_q;
  assign busy      = busy_q;

endmodule
